// File: rtl/fpu_f2i_bf16_if.sv
// Operand and result bundle for the bfloat16-to-integer converter.
// The master drives operands and flush; the slave (the converter) drives results.
interface fpu_f2i_bf16_if;
  logic        F2I_input_valid;
  logic [15:0] F2I_input_float;
  logic        F2I_input_signed;
  logic [2:0]  F2I_input_rm;
  logic        F2I_flush;
  logic        F2I_output_valid;
  logic [31:0] F2I_output_int;
  logic [4:0]  F2I_output_flags;

  modport master (
    output F2I_input_valid, F2I_input_float, F2I_input_signed, F2I_input_rm, F2I_flush,
    input  F2I_output_valid, F2I_output_int, F2I_output_flags
  );

  modport slave (
    input  F2I_input_valid, F2I_input_float, F2I_input_signed, F2I_input_rm, F2I_flush,
    output F2I_output_valid, F2I_output_int, F2I_output_flags
  );
endinterface

// File: rtl/fpu_f2i_bf16.sv
// Two-stage bfloat16 to int32/uint32 converter with RISC-V FCVT.W/WU rounding
// and fflags. Stage 1 decodes the operand; stage 2 shifts, rounds, saturates.
module fpu_f2i_bf16 (
  input logic           clk,
  input logic           rst_l,
  fpu_f2i_bf16_if.slave f2i
);

  logic [7:0] w_exp;
  logic [6:0] w_mant;

  logic              r_vld_p1;
  logic              r_sign_p1;
  logic [2:0]        r_rm_p1;
  logic              r_signed_p1;
  logic signed [8:0] r_exp_p1;
  logic [7:0]        r_sig_p1;
  logic              r_nan_p1;
  logic              r_inf_p1;
  logic              r_zero_p1;

  logic        r_vld_p2;
  logic [31:0] r_int_p2;
  logic [4:0]  r_flags_p2;

  logic [32:0] w_mag;
  logic        w_round;
  logic        w_sticky;
  logic        w_big;
  logic [4:0]  w_lsh;
  logic [3:0]  w_rsh;
  logic [15:0] w_rsh_v;
  logic [32:0] w_rounded;
  logic [36:0] w_res;

  // Rounding increment for the five RISC-V modes; 5-7 behave as RTZ.
  function automatic logic rnd_inc(input logic [2:0] rm, input logic sign,
                                   input logic round, input logic sticky, input logic lsb);
    case (rm)
      3'd0:    rnd_inc = round & (sticky | lsb);
      3'd2:    rnd_inc = sign & (round | sticky);
      3'd3:    rnd_inc = ~sign & (round | sticky);
      3'd4:    rnd_inc = round;
      default: rnd_inc = 1'b0;
    endcase
  endfunction

  // Range check and saturation; returns {flags, result}.
  function automatic logic [36:0] saturate(input logic [32:0] m, input logic sign,
                                           input logic signd, input logic nan,
                                           input logic inf, input logic big,
                                           input logic inexact);
    logic        ovf;
    logic        nv;
    logic [31:0] res;
    if (signd)
      ovf = sign ? (m > 33'h080000000) : (m > 33'h07FFFFFFF);
    else
      ovf = sign ? (m != 33'd0) : m[32];
    nv = nan | inf | big | ovf;
    if (nan)
      res = signd ? 32'h7FFFFFFF : 32'hFFFFFFFF;
    else if (nv)
      res = sign ? (signd ? 32'h80000000 : 32'h00000000)
                 : (signd ? 32'h7FFFFFFF : 32'hFFFFFFFF);
    else
      res = sign ? -m[31:0] : m[31:0];
    saturate = {nv, 3'b000, ~nv & inexact, res};
  endfunction

  assign w_exp  = f2i.F2I_input_float[14:7];
  assign w_mant = f2i.F2I_input_float[6:0];

  // Stage valid bits: flush and reset both drop everything in flight.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p1 <= f2i.F2I_input_valid & ~f2i.F2I_flush;
      r_vld_p2 <= r_vld_p1 & ~f2i.F2I_flush;
    end
  end

  // ---- stage 1: decode ----
  always_ff @(posedge clk) begin
    if (f2i.F2I_input_valid) begin
      r_sign_p1   <= f2i.F2I_input_float[15];
      r_rm_p1     <= f2i.F2I_input_rm;
      r_signed_p1 <= f2i.F2I_input_signed;
      r_exp_p1    <= $signed({1'b0, w_exp}) - 9'sd127;
      r_sig_p1    <= {w_exp != 8'd0, w_mant};
      r_nan_p1    <= (w_exp == 8'hFF) && (w_mant != 7'd0);
      r_inf_p1    <= (w_exp == 8'hFF) && (w_mant == 7'd0);
      r_zero_p1   <= (w_exp == 8'd0) && (w_mant == 7'd0);
    end
  end

  // Align the significand to an integer magnitude plus round/sticky bits.
  always_comb begin
    w_mag    = '0;
    w_round  = 1'b0;
    w_sticky = 1'b0;
    w_big    = 1'b0;
    w_lsh    = '0;
    w_rsh    = '0;
    w_rsh_v  = '0;
    if (r_exp_p1 > 9'sd31) begin
      w_big = 1'b1;
    end else if (r_exp_p1 >= 9'sd7) begin
      w_lsh = r_exp_p1[4:0] - 5'd7;
      w_mag = {25'b0, r_sig_p1} << w_lsh;
    end else if (r_exp_p1 >= -9'sd1) begin
      // E in [-1,6] maps to a right shift of 8..1; E = -1 wraps to 8 in 4 bits.
      w_rsh    = 4'd7 - r_exp_p1[3:0];
      w_rsh_v  = {r_sig_p1, 8'b0} >> w_rsh;
      w_mag    = {25'b0, w_rsh_v[15:8]};
      w_round  = w_rsh_v[7];
      w_sticky = |w_rsh_v[6:0];
    end else begin
      w_sticky = |r_sig_p1;
    end
  end

  assign w_rounded = w_mag + {32'b0, rnd_inc(r_rm_p1, r_sign_p1, w_round, w_sticky, w_mag[0])};
  assign w_res     = saturate(w_rounded, r_sign_p1, r_signed_p1, r_nan_p1, r_inf_p1,
                              w_big, ~r_zero_p1 & (w_round | w_sticky));

  // ---- stage 2: round and saturate; results hold while no op completes ----
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_int_p2   <= '0;
      r_flags_p2 <= '0;
    end else if (r_vld_p1 && !f2i.F2I_flush) begin
      r_flags_p2 <= w_res[36:32];
      r_int_p2   <= w_res[31:0];
    end
  end

  assign f2i.F2I_output_valid = r_vld_p2;
  assign f2i.F2I_output_int   = r_int_p2;
  assign f2i.F2I_output_flags = r_flags_p2;

endmodule

// File: tb/tb_fpu_f2i_bf16.sv
// Directed-vector bench for the bfloat16-to-integer converter.
module tb_fpu_f2i_bf16;

  logic clk;
  logic rst_l;

  fpu_f2i_bf16_if bus();

  fpu_f2i_bf16 dut (
    .clk   (clk),
    .rst_l (rst_l),
    .f2i   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] f;
    logic        sgn;
    logic [2:0]  rm;
    logic [31:0] ei;
    logic [4:0]  ef;
  } vec_t;

  localparam int NV = 25;
  vec_t vt [NV];

  int n_vec;
  int n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] f, input logic s, input logic [2:0] rm);
    bus.F2I_input_valid  = v;
    bus.F2I_input_float  = f;
    bus.F2I_input_signed = s;
    bus.F2I_input_rm     = rm;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    //          float     sgn   rm    int            flags
    vt[0]  = {16'h3FC0, 1'b1, 3'd0, 32'h00000002, 5'h01};
    vt[1]  = {16'h3FC0, 1'b1, 3'd1, 32'h00000001, 5'h01};
    vt[2]  = {16'h3FC0, 1'b1, 3'd4, 32'h00000002, 5'h01};
    vt[3]  = {16'h4049, 1'b1, 3'd2, 32'h00000003, 5'h01};
    vt[4]  = {16'hC049, 1'b1, 3'd2, 32'hFFFFFFFC, 5'h01};
    vt[5]  = {16'hC049, 1'b1, 3'd3, 32'hFFFFFFFD, 5'h01};
    vt[6]  = {16'h4F00, 1'b1, 3'd1, 32'h7FFFFFFF, 5'h10};
    vt[7]  = {16'h4F00, 1'b0, 3'd1, 32'h80000000, 5'h00};
    vt[8]  = {16'hCF00, 1'b1, 3'd1, 32'h80000000, 5'h00};
    vt[9]  = {16'h4F80, 1'b0, 3'd1, 32'hFFFFFFFF, 5'h10};
    vt[10] = {16'h7FC0, 1'b1, 3'd0, 32'h7FFFFFFF, 5'h10};
    vt[11] = {16'hFF80, 1'b0, 3'd0, 32'h00000000, 5'h10};
    vt[12] = {16'h8000, 1'b0, 3'd0, 32'h00000000, 5'h00};
    vt[13] = {16'hBE80, 1'b0, 3'd1, 32'h00000000, 5'h01};
    vt[14] = {16'hBE80, 1'b0, 3'd2, 32'h00000000, 5'h10};
    vt[15] = {16'h3F00, 1'b1, 3'd0, 32'h00000000, 5'h01};  // 0.5 ties to even 0
    vt[16] = {16'h3F00, 1'b1, 3'd4, 32'h00000001, 5'h01};  // 0.5 ties away
    vt[17] = {16'h3FC0, 1'b1, 3'd5, 32'h00000001, 5'h01};  // rm 5 acts as RTZ
    vt[18] = {16'h0001, 1'b1, 3'd3, 32'h00000001, 5'h01};  // subnormal rounds up
    vt[19] = {16'hCF01, 1'b1, 3'd1, 32'h80000000, 5'h10};  // below -2^31
    vt[20] = {16'h4F7F, 1'b0, 3'd1, 32'hFF000000, 5'h00};  // largest in-range uint
    vt[21] = {16'hC000, 1'b0, 3'd1, 32'h00000000, 5'h10};  // -2 to uint
    vt[22] = {16'h7F80, 1'b1, 3'd0, 32'h7FFFFFFF, 5'h10};  // +Inf
    vt[23] = {16'h4020, 1'b1, 3'd0, 32'h00000002, 5'h01};  // 2.5 ties to even 2
    vt[24] = {16'hBFC0, 1'b1, 3'd0, 32'hFFFFFFFE, 5'h01};  // -1.5 ties to -2

    rst_l = 1'b0;
    bus.F2I_flush = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 3'd0);
    repeat (2) @(negedge clk);
    chk("reset_valid", {31'b0, bus.F2I_output_valid}, 32'd0);
    chk("reset_int",   bus.F2I_output_int, 32'd0);
    chk("reset_flags", {27'b0, bus.F2I_output_flags}, 32'd0);
    rst_l = 1'b1;
    @(negedge clk);

    // Isolated vectors: result appears two edges after the operand is driven.
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, vt[i].f, vt[i].sgn, vt[i].rm);
      @(negedge clk);
      drive(1'b0, 16'h0000, 1'b0, 3'd0);
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), {31'b0, bus.F2I_output_valid}, 32'd1);
      chk($sformatf("v%0d_int", i),   bus.F2I_output_int, vt[i].ei);
      chk($sformatf("v%0d_flags", i), {27'b0, bus.F2I_output_flags}, {27'b0, vt[i].ef});
      @(negedge clk);
      chk($sformatf("v%0d_pulse_end", i), {31'b0, bus.F2I_output_valid}, 32'd0);
    end

    // Back-to-back: 1.0, 2.0, 3.0 signed RTZ give pulses at offsets 2,3,4.
    drive(1'b1, 16'h3F80, 1'b1, 3'd1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("b2b_valid_%0d", k), {31'b0, bus.F2I_output_valid},
          (k >= 2 && k <= 4) ? 32'd1 : 32'd0);
      if (k >= 2 && k <= 4)
        chk($sformatf("b2b_int_%0d", k), bus.F2I_output_int, k - 1);
      if (k == 1)      drive(1'b1, 16'h4000, 1'b1, 3'd1);
      else if (k == 2) drive(1'b1, 16'h4040, 1'b1, 3'd1);
      else             drive(1'b0, 16'h0000, 1'b0, 3'd0);
    end

    // Flush presented with op 2: op 1 (1.0) still pulses, op 2 (2.0) is dropped.
    drive(1'b1, 16'h3F80, 1'b1, 3'd1);
    @(negedge clk);
    drive(1'b0, 16'h0000, 1'b0, 3'd0);
    @(negedge clk);
    chk("flush_op1_valid", {31'b0, bus.F2I_output_valid}, 32'd1);
    chk("flush_op1_int",   bus.F2I_output_int, 32'd1);
    drive(1'b1, 16'h4000, 1'b1, 3'd1);
    bus.F2I_flush = 1'b1;
    @(negedge clk);
    drive(1'b0, 16'h0000, 1'b0, 3'd0);
    bus.F2I_flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("flush_op2_none_%0d", k), {31'b0, bus.F2I_output_valid}, 32'd0);
      @(negedge clk);
    end

    // Flush one cycle after an operand kills it in flight; output data holds.
    drive(1'b1, 16'h4040, 1'b1, 3'd1);
    @(negedge clk);
    drive(1'b0, 16'h0000, 1'b0, 3'd0);
    bus.F2I_flush = 1'b1;
    @(negedge clk);
    bus.F2I_flush = 1'b0;
    chk("flush_inflight_valid", {31'b0, bus.F2I_output_valid}, 32'd0);
    chk("flush_hold_int",       bus.F2I_output_int, 32'd1);
    @(negedge clk);
    chk("flush_inflight_late",  {31'b0, bus.F2I_output_valid}, 32'd0);

    // Reset one cycle after an operand: no pulse, outputs cleared.
    drive(1'b1, 16'h4040, 1'b1, 3'd1);
    @(negedge clk);
    drive(1'b0, 16'h0000, 1'b0, 3'd0);
    rst_l = 1'b0;
    #1;
    chk("rst_mid_valid", {31'b0, bus.F2I_output_valid}, 32'd0);
    chk("rst_mid_int",   bus.F2I_output_int, 32'd0);
    chk("rst_mid_flags", {27'b0, bus.F2I_output_flags}, 32'd0);
    @(negedge clk);
    rst_l = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst_after_valid_%0d", k), {31'b0, bus.F2I_output_valid}, 32'd0);
    end
    chk("rst_after_int", bus.F2I_output_int, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fpu_f2i_bf16.md
# fpu_f2i_bf16

Pipelined bfloat16-to-integer converter, the F2I counterpart of the FPU's I2F datapath. It accepts one bfloat16 operand per cycle and produces a 32-bit signed or unsigned integer two cycles later. Rounding follows RISC-V `FCVT.W/WU` semantics, and results come with RISC-V fflags. It sits beside the I2F path in the FPU execute stage and shares its valid/flush sequencing.

## Interface
- No parameters. Widths are fixed: bf16 in, 32-bit integer out.
- `clk`  in  1  rising-edge clock
- `rst_l`  in  1  asynchronous, active-low reset
- `F2I_input_valid`  in  1  operand presented this cycle
- `F2I_input_float`  in  16  bfloat16 operand: `[15]` sign, `[14:7]` exponent, `[6:0]` mantissa
- `F2I_input_signed`  in  1  1 = int32 result, 0 = uint32 result
- `F2I_input_rm`  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; values 5–7 are treated as RTZ with no flag
- `F2I_flush`  in  1  synchronous kill of every op in flight
- `F2I_output_valid`  out  1  one-cycle pulse per completed op
- `F2I_output_int`  out  32  converted integer
- `F2I_output_flags`  out  5  `{NV, DZ, OF, UF, NX}`; DZ, OF and UF are always 0

## Operation
- **Stage 1 (decode), registered:**
  - Capture sign, rm, and the signed flag.
  - Compute the unbiased exponent `E = exp − 127` as a 9-bit signed value.
  - Build the significand `sig = {exp != 0, mant}` (8 bits). Subnormals therefore have magnitude below 1.
  - Classify the operand as NaN (`exp == FF`, `mant != 0`), Inf (`exp == FF`, `mant == 0`) or zero (`exp == 0`, `mant == 0`).
- **Stage 2 (shift, round, saturate), registered:**
  - `E ≥ 7`: `mag = sig << (E − 7)`; round and sticky bits are 0. If `E > 31`, the op is forced to overflow.
  - `0 ≤ E < 7`: `mag = sig >> (7 − E)`; the round bit is the next bit below; sticky is the OR of the remaining bits.
  - `E == −1`: `mag = 0`, `round = sig[7]`, `sticky = |sig[6:0]`.
  - `E < −1`: `mag = 0`, `round = 0`, `sticky = |sig`.
- **Rounding increment:**
  - RNE: `round & (sticky | mag[0])`
  - RTZ: 0
  - RDN: `sign & (round | sticky)`
  - RUP: `~sign & (round | sticky)`
  - RMM: `round`
  - The rounded magnitude is 33 bits wide.
- **Range check on the rounded magnitude M:**
  - Signed: positive requires `M ≤ 2^31 − 1`; negative requires `M ≤ 2^31`. The result is `sign ? −M : M`.
  - Unsigned: positive requires `M ≤ 2^32 − 1`. For negative input, `M == 0` gives result 0 with no NV; `M != 0` is invalid.
- **Invalid (NV = 1, NX = 0):**
  - Signed: NaN, +Inf or +overflow gives `7FFFFFFF`; −Inf or −overflow gives `80000000`.
  - Unsigned: NaN, +Inf or +overflow gives `FFFFFFFF`; any negative invalid gives `00000000`.
- **NX** = `round | sticky` when NV = 0. Zero operands (±0) give result 0 with flags 0.
- **Flush:** `F2I_flush` clears both stage valid bits at the next edge. An operand presented in the same cycle as flush is dropped. Data registers are not cleared.

## Timing
- Latency is 2. An operand sampled at edge N has its result and `F2I_output_valid` visible after edge N+2.
- Throughput is one op per cycle; there is no backpressure and no ready signal.
- `F2I_output_int` and `F2I_output_flags` hold their last value while `F2I_output_valid` is 0.
- Reset (asynchronous, `rst_l` = 0) clears:
  - both stage valid bits, so `F2I_output_valid` = 0;
  - `F2I_output_int` to `00000000`;
  - `F2I_output_flags` to `00000`.
- Reset asserted mid-operation discards all in-flight ops; no output pulse follows release.
- Flush and reset take priority over a new input in the same cycle.

## Test plan
- **Ties and truncation:** `3FC0` (1.5), signed.
  - RNE → `00000002`, flags `01`.
  - RTZ → `00000001`, flags `01`.
  - RMM → `00000002`, flags `01`.
- **Directed rounding:** `4049` (3.140625), RDN → `00000003`, flags `01`. `C049`, RDN → `FFFFFFFC`, flags `01`. `C049`, RUP → `FFFFFFFD`, flags `01`.
- **Range edges:**
  - `4F00` (2^31), signed → `7FFFFFFF`, flags `10`.
  - `4F00`, unsigned → `80000000`, flags `00`.
  - `CF00` (−2^31), signed → `80000000`, flags `00`.
  - `4F80` (2^32), unsigned → `FFFFFFFF`, flags `10`.
- **Specials:**
  - `7FC0` (NaN), signed → `7FFFFFFF`, flags `10`.
  - `FF80` (−Inf), unsigned → `00000000`, flags `10`.
  - `8000` (−0), unsigned → `00000000`, flags `00`.
- **Small negative, unsigned:** `BE80` (−0.25).
  - RTZ → `00000000`, flags `01`.
  - RDN → `00000000`, flags `10`.
- **Pipeline:**
  - Three back-to-back valid ops yield three consecutive output pulses starting 2 cycles after the first.
  - Asserting flush in the cycle the second op is presented yields exactly one pulse, for op 1.
  - Dropping `rst_l` one cycle after an input yields no pulse and all outputs reading 0.
